user_pulser_sequencer: RTL and testbench
========================================

USER_PULSER_SEQUENCER -- requirements
Module: user_pulser_sequencer

Interface
REQ-001 Parameter ObiCfg, default obi_pkg::ObiDefaultConfig, OBI bus configuration.
REQ-002 Parameters obi_req_t / obi_rsp_t, default logic, OBI request/response structs.
REQ-003 Parameter N_PULSER_INST, default 4, pulser count, range 1..8.
REQ-004 Parameter N_STEPS, default 8, step-table depth, range 1..16.
REQ-005 clk_i  in  1  sole clock.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 obi_req_i  in  obi_req_t  OBI subordinate request.
REQ-008 obi_rsp_o  out  obi_rsp_t  OBI subordinate response.
REQ-009 ready_i  in  N_PULSER_INST  per-pulser ready, high when the pulser is IDLE or DONE.
REQ-010 start_o / stop_o  out  N_PULSER_INST each  one-cycle start/stop strobes to the pulsers.
REQ-011 busy_o  out  1  sequence running; done_o  out  1  one-cycle strobe at sequence end.

Function
REQ-012 OBI: gnt = req; rvalid, rid and rdata SHALL be registered one cycle after grant; err = 0.
REQ-013 Map, word offsets on addr[7:0]:
- 0x00 CTRL: write bit0 = go, bit1 = abort; read {busy, done_sticky, 26'b0, step_idx[3:0]}.
- 0x04 LEN: number of steps, 0..N_STEPS.
- 0x40+4k STEP[k], k < N_STEPS: [7:0] start mask, [15:8] stop mask, [30:16] wait, [31] wait_rdy.
- Unmapped reads SHALL return 0xDEADBEEF.
REQ-014 FSM states: IDLE, ISSUE, WAIT_CNT, WAIT_RDY, DONE.
REQ-015 A go write in IDLE or DONE with LEN>0 SHALL clear step_idx and done_sticky and enter ISSUE on the cycle after the write response.
REQ-016 ISSUE (one cycle):
- Drive start_o/stop_o with the STEP[step_idx] masks, truncated to N_PULSER_INST bits.
- Load the counter with wait, then go to WAIT_CNT.
REQ-017 WAIT_CNT SHALL decrement the counter each cycle and exit in the cycle the counter equals 0. Issue-to-issue spacing is wait+2 cycles.
REQ-018 On WAIT_CNT exit with wait_rdy=1, enter WAIT_RDY. WAIT_RDY SHALL hold until (ready_i & start mask) == start mask. An empty mask passes immediately.
REQ-019 Step advance: if step_idx < LEN-1, increment and return to ISSUE; otherwise DONE.
REQ-020 DONE SHALL pulse done_o for one cycle, set done_sticky, and return to IDLE.
REQ-021 A go write while busy SHALL be ignored. A go write with LEN=0 SHALL set done_sticky and pulse done_o without issuing any strobes.
REQ-022 Abort in any non-IDLE state:
- Enter IDLE next cycle.
- Drive stop_o to all ones for one cycle.
- Leave done_sticky unchanged.
Abort has priority over a go in the same write.
REQ-023 STEP/LEN writes while busy SHALL be accepted and take effect at the next ISSUE that reads them.
REQ-024 LEN writes greater than N_STEPS SHALL saturate to N_STEPS.
REQ-025 busy_o = (state != IDLE).

Reset
REQ-026 Reset SHALL clear:
- FSM to IDLE.
- step_idx, counter, LEN, all STEP entries, done_sticky.
- start_o, stop_o, busy_o, done_o to 0.
- OBI rvalid to 0.
REQ-027 Reset mid-sequence SHALL emit no further strobes.

Configuration
REQ-028 With USER_PULSER_SEQ_LOOP_EN defined:
- Add LOOP register at 0x08, [7:0] loops.
- The sequence SHALL run loops+1 times, step_idx wrapping to 0 between passes.
- done_o SHALL fire only after the final pass.
- CTRL read bits [11:4] SHALL show the remaining loops.
REQ-029 Without USER_PULSER_SEQ_LOOP_EN: offset 0x08 reads 0xDEADBEEF and the sequence runs once.

Structure
REQ-030 Package user_pulser_seq_pkg SHALL hold the FSM state enum, the step_t struct and the register offset constants.
REQ-031 The step table SHALL be sub-module user_pulser_seq_table, with one write port and two combinational read ports (OBI readback and FSM).

Verification
REQ-032 LEN=2, STEP0={start 0x1, wait 3}, STEP1={start 0x2, wait 0}, go:
- start_o=0x1 at T, start_o=0x2 at T+5.
- done_o at T+7; busy_o low at T+8.
REQ-033 STEP0={start 0x3, wait_rdy 1}, ready_i=0x1 for 10 cycles then 0x3: no advance until ready_i=0x3; DONE one cycle after.
REQ-034 Abort during WAIT_CNT of a 1000-cycle wait: stop_o=0xF for one cycle, busy_o=0, done_sticky=0.
REQ-035 LEN=0 go -> done_o pulse, no start_o. Go while busy -> ignored. LEN write of 20 -> readback 8.
REQ-036 With USER_PULSER_SEQ_LOOP_EN, LOOP=2, LEN=1, wait 0 -> three start_o pulses 2 cycles apart, one done_o.
REQ-037 Assert rst_ni low during ISSUE -> all outputs 0 immediately; no strobe after release.

Source files
------------

// File: rtl/user_pulser_seq_pkg.sv
// ============================================================================
// Module : user_pulser_seq_pkg
// Brief  : Shared types, FSM state encodings and register offsets for the
//          pulser sequencer (optional loop feature: USER_PULSER_SEQ_LOOP_EN).
// Rev    : 1.0
// ============================================================================
`default_nettype none

package user_pulser_seq_pkg;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};
    localparam int OBI_ID_W = 1;

    typedef struct packed {
        logic [31:0]         addr;
        logic                we;
        logic [3:0]          be;
        logic [31:0]         wdata;
        logic [OBI_ID_W-1:0] aid;
    } seq_obi_a_chan_t;

    typedef struct packed {
        seq_obi_a_chan_t a;
        logic            req;
    } seq_obi_req_t;

    typedef struct packed {
        logic [31:0]         rdata;
        logic [OBI_ID_W-1:0] rid;
        logic                err;
    } seq_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        seq_obi_r_chan_t r;
    } seq_obi_rsp_t;

    // Step word layout: [31] wait_rdy, [30:16] wait, [15:8] stop, [7:0] start
    typedef struct packed {
        logic        wait_rdy;
        logic [14:0] wait_cycles;
        logic [7:0]  stop_mask;
        logic [7:0]  start_mask;
    } step_t;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ISSUE    = 3'd1;
    localparam logic [2:0] ST_WAIT_CNT = 3'd2;
    localparam logic [2:0] ST_WAIT_RDY = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    localparam logic [7:0] OFF_CTRL = 8'h00;
    localparam logic [7:0] OFF_LEN  = 8'h04;
    localparam logic [7:0] OFF_LOOP = 8'h08;

endpackage

`default_nettype wire

// File: rtl/user_pulser_seq_table.sv
// ============================================================================
// Module : user_pulser_seq_table
// Brief  : Step table, one write port and two combinational read ports.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module user_pulser_seq_table #(
    parameter int N_STEPS = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic [3:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  raddr_a_i,
    output logic [31:0] rdata_a_o,
    input  logic [3:0]  raddr_b_i,
    output logic [31:0] rdata_b_o
);

    logic [31:0] r_mem [N_STEPS];

    for (genvar g = 0; g < N_STEPS; g++) begin : g_entry
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_mem[g] <= '0;
            end else if (we_i && (waddr_i == 4'(g))) begin
                r_mem[g] <= wdata_i;
            end
        end
    end

    // Out-of-range addresses read as zero
    always_comb begin
        rdata_a_o = '0;
        rdata_b_o = '0;
        for (int k = 0; k < N_STEPS; k++) begin
            if (raddr_a_i == 4'(k)) rdata_a_o = r_mem[k];
            if (raddr_b_i == 4'(k)) rdata_b_o = r_mem[k];
        end
    end

endmodule

`default_nettype wire

// File: rtl/user_pulser_sequencer.sv
// ============================================================================
// Module : user_pulser_sequencer
// Brief  : OBI-programmed step sequencer issuing start/stop strobes to pulsers.
//          Define USER_PULSER_SEQ_LOOP_EN to add the LOOP repeat register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module user_pulser_sequencer
    import user_pulser_seq_pkg::*;
#(
    parameter obi_cfg_t ObiCfg        = ObiDefaultConfig,
    parameter type      obi_req_t     = seq_obi_req_t,
    parameter type      obi_rsp_t     = seq_obi_rsp_t,
    parameter int       N_PULSER_INST = 4,
    parameter int       N_STEPS       = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  obi_req_t                 obi_req_i,
    output obi_rsp_t                 obi_rsp_o,
    input  logic [N_PULSER_INST-1:0] ready_i,
    output logic [N_PULSER_INST-1:0] start_o,
    output logic [N_PULSER_INST-1:0] stop_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int DW = ObiCfg.DataWidth;

    logic [2:0]          r_state;
    logic                r_go_pending;
    logic                r_abort_stop;
    logic                r_done_sticky;
    logic [3:0]          r_step_idx;
    logic [14:0]         r_count;
    logic [4:0]          r_len;
    logic                r_rvalid;
    logic [DW-1:0]       r_rdata;
    logic [OBI_ID_W-1:0] r_rid;
`ifdef USER_PULSER_SEQ_LOOP_EN
    logic [7:0]          r_loop_cfg;
    logic [7:0]          r_loops_left;
    logic [7:0]          w_adv_loops;
`endif

    logic [7:0]  w_addr;
    logic [31:0] w_wdata;
    logic        w_wr;
    logic        w_ctrl_sel, w_len_sel, w_step_sel;
    logic        w_go, w_abort;
    logic [31:0] w_step_rd_raw, w_step_raw;
    step_t       w_step;
    logic [N_PULSER_INST-1:0] w_start_mask;
    logic        w_more_steps;
    logic [2:0]  w_adv_state;
    logic [3:0]  w_adv_idx;
    logic [DW-1:0] w_rdata;
    logic        w_unused;

    assign w_addr     = obi_req_i.a.addr[7:0];
    assign w_wdata    = obi_req_i.a.wdata;
    assign w_wr       = obi_req_i.req & obi_req_i.a.we;
    assign w_ctrl_sel = (w_addr == OFF_CTRL);
    assign w_len_sel  = (w_addr == OFF_LEN);
    assign w_step_sel = (w_addr[7:6] == 2'b01) && (w_addr[1:0] == 2'b00) &&
                        (32'(w_addr[5:2]) < 32'(N_STEPS));
    assign w_abort    = w_wr & w_ctrl_sel & w_wdata[1];
    assign w_go       = w_wr & w_ctrl_sel & w_wdata[0] & ~w_wdata[1];

    user_pulser_seq_table #(.N_STEPS(N_STEPS)) u_table (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .we_i      (w_wr & w_step_sel),
        .waddr_i   (w_addr[5:2]),
        .wdata_i   (w_wdata),
        .raddr_a_i (w_addr[5:2]),
        .rdata_a_o (w_step_rd_raw),
        .raddr_b_i (r_step_idx),
        .rdata_b_o (w_step_raw)
    );

    assign w_step       = step_t'(w_step_raw);
    assign w_start_mask = w_step.start_mask[N_PULSER_INST-1:0];
    assign w_unused     = ^{obi_req_i.a.addr[31:8], obi_req_i.a.be, w_step_raw};

    always_comb begin
        w_rdata = DW'(32'hDEADBEEF);
        if (w_ctrl_sel) begin
            w_rdata = DW'({busy_o, r_done_sticky, 26'b0, r_step_idx});
`ifdef USER_PULSER_SEQ_LOOP_EN
            w_rdata[11:4] = r_loops_left;
`endif
        end else if (w_len_sel) begin
            w_rdata = DW'({27'b0, r_len});
`ifdef USER_PULSER_SEQ_LOOP_EN
        end else if (w_addr == OFF_LOOP) begin
            w_rdata = DW'({24'b0, r_loop_cfg});
`endif
        end else if (w_step_sel) begin
            w_rdata = DW'(w_step_rd_raw);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rid    <= '0;
        end else begin
            r_rvalid <= obi_req_i.req;
            if (obi_req_i.req) begin
                r_rdata <= obi_req_i.a.we ? '0 : w_rdata;
                r_rid   <= obi_req_i.a.aid;
            end
        end
    end

    always_comb begin
        obi_rsp_o         = '0;
        obi_rsp_o.gnt     = obi_req_i.req;
        obi_rsp_o.rvalid  = r_rvalid;
        obi_rsp_o.r.rdata = r_rdata;
        obi_rsp_o.r.rid   = r_rid;
        obi_rsp_o.r.err   = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_len <= '0;
`ifdef USER_PULSER_SEQ_LOOP_EN
            r_loop_cfg <= '0;
`endif
        end else begin
            if (w_wr && w_len_sel) begin
                r_len <= (w_wdata > 32'(N_STEPS)) ? 5'(N_STEPS) : w_wdata[4:0];
            end
`ifdef USER_PULSER_SEQ_LOOP_EN
            if (w_wr && (w_addr == OFF_LOOP)) r_loop_cfg <= w_wdata[7:0];
`endif
        end
    end

    // LEN is compared live so a shrink while busy ends the run early
    always_comb begin
        w_more_steps = ({1'b0, r_step_idx} + 5'd1) < r_len;
        w_adv_state  = ST_DONE;
        w_adv_idx    = r_step_idx;
`ifdef USER_PULSER_SEQ_LOOP_EN
        w_adv_loops  = r_loops_left;
`endif
        if (w_more_steps) begin
            w_adv_state = ST_ISSUE;
            w_adv_idx   = r_step_idx + 4'd1;
`ifdef USER_PULSER_SEQ_LOOP_EN
        end else if (r_loops_left != 8'd0) begin
            w_adv_state = ST_ISSUE;
            w_adv_idx   = 4'd0;
            w_adv_loops = r_loops_left - 8'd1;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= ST_IDLE;
            r_go_pending  <= 1'b0;
            r_abort_stop  <= 1'b0;
            r_done_sticky <= 1'b0;
            r_step_idx    <= '0;
            r_count       <= '0;
`ifdef USER_PULSER_SEQ_LOOP_EN
            r_loops_left  <= '0;
`endif
        end else begin
            r_abort_stop <= 1'b0;
            if (w_abort) begin
                r_go_pending <= 1'b0;
                if (r_state != ST_IDLE) begin
                    r_state      <= ST_IDLE;
                    r_abort_stop <= 1'b1;
                end
            end else begin
                r_go_pending <= w_go && ((r_state == ST_IDLE) || (r_state == ST_DONE));
                case (r_state)
                    ST_IDLE: begin
                        if (r_go_pending) begin
                            r_step_idx    <= '0;
                            r_done_sticky <= 1'b0;
`ifdef USER_PULSER_SEQ_LOOP_EN
                            r_loops_left  <= r_loop_cfg;
`endif
                            r_state <= (r_len == 5'd0) ? ST_DONE : ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        r_count <= w_step.wait_cycles;
                        r_state <= ST_WAIT_CNT;
                    end
                    ST_WAIT_CNT: begin
                        if (r_count != 15'd0) begin
                            r_count <= r_count - 15'd1;
                        end else if (w_step.wait_rdy) begin
                            r_state <= ST_WAIT_RDY;
                        end else begin
                            r_state    <= w_adv_state;
                            r_step_idx <= w_adv_idx;
`ifdef USER_PULSER_SEQ_LOOP_EN
                            r_loops_left <= w_adv_loops;
`endif
                        end
                    end
                    ST_WAIT_RDY: begin
                        if ((ready_i & w_start_mask) == w_start_mask) begin
                            r_state    <= w_adv_state;
                            r_step_idx <= w_adv_idx;
`ifdef USER_PULSER_SEQ_LOOP_EN
                            r_loops_left <= w_adv_loops;
`endif
                        end
                    end
                    ST_DONE: begin
                        r_done_sticky <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign start_o = (r_state == ST_ISSUE) ? w_start_mask : '0;
    assign stop_o  = r_abort_stop ? '1 :
                     ((r_state == ST_ISSUE) ? w_step.stop_mask[N_PULSER_INST-1:0] : '0);
    assign busy_o  = (r_state != ST_IDLE);
    assign done_o  = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_user_pulser_sequencer.sv
// ============================================================================
// Module : tb_user_pulser_sequencer
// Brief  : Self-checking bench for user_pulser_sequencer (honours
//          USER_PULSER_SEQ_LOOP_EN when defined).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_user_pulser_sequencer;
    import user_pulser_seq_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    seq_obi_req_t req;
    seq_obi_rsp_t rsp;
    logic [3:0]   ready;
    logic [3:0]   start, stop;
    logic         busy, done;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    user_pulser_sequencer #(
        .obi_req_t     (seq_obi_req_t),
        .obi_rsp_t     (seq_obi_rsp_t),
        .N_PULSER_INST (4),
        .N_STEPS       (8)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .obi_req_i (req),
        .obi_rsp_o (rsp),
        .ready_i   (ready),
        .start_o   (start),
        .stop_o    (stop),
        .busy_o    (busy),
        .done_o    (done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic obi_write(input logic [7:0] addr, input logic [31:0] data);
        req.req     = 1'b1;
        req.a.we    = 1'b1;
        req.a.addr  = {24'b0, addr};
        req.a.wdata = data;
        req.a.be    = 4'hF;
        req.a.aid   = 1'b0;
        tick();
        req.req  = 1'b0;
        req.a.we = 1'b0;
    endtask

    task automatic obi_read(input logic [7:0] addr, input logic [31:0] expv, input string name);
        logic [31:0] e;
        exp_q.push_back(expv);
        req.req    = 1'b1;
        req.a.we   = 1'b0;
        req.a.addr = {24'b0, addr};
        req.a.aid  = 1'b1;
        tick();
        req.req = 1'b0;
        e = exp_q.pop_front();
        tests_run++;
        if (rsp.rvalid !== 1'b1 || rsp.r.rid !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s: rvalid=%b rid=%b, required rvalid=1 rid=1", name, rsp.rvalid, rsp.r.rid);
        end else if (rsp.r.rdata !== e) begin
            tests_failed++;
            $display("FAIL %s: rdata=%h, required %h", name, rsp.r.rdata, e);
        end
    endtask

    task automatic wait_start(input string name);
        for (int i = 0; i < 20; i++) begin
            if (start !== 4'h0) break;
            tick();
        end
        tests_run++;
        if (start === 4'h0) begin
            tests_failed++;
            $display("FAIL %s: no start_o strobe within 20 cycles", name);
        end
    endtask

    task automatic test_reset;
        tick(); tick();
        tests_run++;
        if ({start, stop, busy, done, rsp.rvalid} !== 11'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: start=%h stop=%h busy=%b done=%b rvalid=%b, required all 0",
                     start, stop, busy, done, rsp.rvalid);
        end
        rst_n = 1'b1;
        tick();
        obi_read(8'h00, 32'h0, "reset_ctrl");
        obi_read(8'h04, 32'h0, "reset_len");
        obi_read(8'h40, 32'h0, "reset_step0");
        tests_run++;
        if (rsp.r.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_err: err=%b, required 0", rsp.r.err);
        end
    endtask

    task automatic test_map;
        obi_write(8'h4C, 32'h8001_2345);
        obi_read(8'h4C, 32'h8001_2345, "step3_readback");
        obi_read(8'h10, 32'hDEADBEEF, "unmapped_0x10");
        obi_read(8'h60, 32'hDEADBEEF, "step8_unmapped");
`ifdef USER_PULSER_SEQ_LOOP_EN
        obi_read(8'h08, 32'h0, "loop_reg_reset");
`else
        obi_read(8'h08, 32'hDEADBEEF, "loop_reg_absent");
`endif
    endtask

    task automatic test_basic;
        logic [3:0] es;
        obi_write(8'h40, 32'h0003_0001);
        obi_write(8'h44, 32'h0000_0002);
        obi_write(8'h04, 32'd2);
        obi_write(8'h00, 32'h1);
        wait_start("basic_first_start");
        for (int off = 0; off <= 8; off++) begin
            es = (off == 0) ? 4'h1 : ((off == 5) ? 4'h2 : 4'h0);
            tests_run++;
            if (start !== es || stop !== 4'h0 || done !== (off == 7) || busy !== (off < 8)) begin
                tests_failed++;
                $display("FAIL basic_T+%0d: start=%h stop=%h done=%b busy=%b, required start=%h stop=0 done=%b busy=%b",
                         off, start, stop, done, busy, es, (off == 7), (off < 8));
            end
            tick();
        end
        obi_read(8'h00, 32'h4000_0001, "basic_ctrl_after");
    endtask

    task automatic test_wait_rdy;
        ready = 4'h1;
        obi_write(8'h40, 32'h8000_0003);
        obi_write(8'h04, 32'd1);
        obi_write(8'h00, 32'h1);
        wait_start("rdy_start");
        for (int i = 0; i < 10; i++) begin
            tick();
            tests_run++;
            if (done !== 1'b0 || busy !== 1'b1 || start !== 4'h0) begin
                tests_failed++;
                $display("FAIL rdy_hold_%0d: done=%b busy=%b start=%h, required done=0 busy=1 start=0",
                         i, done, busy, start);
            end
        end
        ready = 4'h3;
        tick();
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("FAIL rdy_done: done=%b, required 1", done);
        end
        tick();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rdy_idle: busy=%b, required 0", busy);
        end
        ready = 4'hF;
        obi_read(8'h00, 32'h4000_0000, "rdy_ctrl_after");
    endtask

    task automatic test_abort;
        obi_write(8'h40, 32'h03E8_0001);
        obi_write(8'h04, 32'd1);
        obi_write(8'h00, 32'h1);
        wait_start("abort_start");
        tick(); tick(); tick();
        obi_write(8'h00, 32'h3);
        tests_run++;
        if (stop !== 4'hF || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_stop: stop=%h busy=%b, required stop=f busy=0", stop, busy);
        end
        tick();
        tests_run++;
        if (stop !== 4'h0 || busy !== 1'b0 || start !== 4'h0) begin
            tests_failed++;
            $display("FAIL abort_after: stop=%h busy=%b start=%h, required all 0", stop, busy, start);
        end
        tick();
        tests_run++;
        if (busy !== 1'b0 || start !== 4'h0) begin
            tests_failed++;
            $display("FAIL abort_go_ignored: busy=%b start=%h, required 0 0", busy, start);
        end
        obi_read(8'h00, 32'h0000_0000, "abort_ctrl");
    endtask

    task automatic test_len_zero;
        bit saw_start = 0;
        bit saw_done = 0;
        obi_write(8'h04, 32'd0);
        obi_write(8'h00, 32'h1);
        for (int i = 0; i < 10; i++) begin
            if (start !== 4'h0) saw_start = 1;
            if (done === 1'b1) saw_done = 1;
            tick();
        end
        tests_run++;
        if (!saw_done || saw_start) begin
            tests_failed++;
            $display("FAIL len0_go: done_seen=%b start_seen=%b, required 1 0", saw_done, saw_start);
        end
        obi_read(8'h00, 32'h4000_0000, "len0_ctrl");
        obi_write(8'h04, 32'd20);
        obi_read(8'h04, 32'd8, "len_saturate");
    endtask

    task automatic test_back_to_back;
        int n_start = 0;
        int n_done = 0;
        obi_write(8'h40, 32'h0014_0004);
        obi_write(8'h04, 32'd1);
        obi_write(8'h00, 32'h1);
        wait_start("b2b_start");
        tick();
        obi_write(8'h00, 32'h1);
        for (int i = 0; i < 60; i++) begin
            if (start !== 4'h0) n_start++;
            if (done === 1'b1) n_done++;
            tick();
        end
        tests_run++;
        if (n_start != 0 || n_done != 1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL go_while_busy: extra_starts=%0d dones=%0d busy=%b, required 0 1 0",
                     n_start, n_done, busy);
        end
    endtask

    task automatic test_loop;
`ifdef USER_PULSER_SEQ_LOOP_EN
        logic [3:0] es;
        obi_write(8'h40, 32'h0000_0001);
        obi_write(8'h04, 32'd1);
        obi_write(8'h08, 32'd2);
        obi_read(8'h08, 32'd2, "loop_readback");
        obi_write(8'h00, 32'h1);
        wait_start("loop_start");
        for (int off = 0; off <= 7; off++) begin
            es = (off == 0 || off == 2 || off == 4) ? 4'h1 : 4'h0;
            tests_run++;
            if (start !== es || done !== (off == 6)) begin
                tests_failed++;
                $display("FAIL loop_T+%0d: start=%h done=%b, required start=%h done=%b",
                         off, start, done, es, (off == 6));
            end
            tick();
        end
        obi_write(8'h08, 32'd0);
`else
        obi_write(8'h08, 32'h0000_0005);
        obi_read(8'h08, 32'hDEADBEEF, "loop_write_ignored");
`endif
    endtask

    task automatic test_reset_mid;
        int n_strobe = 0;
        obi_write(8'h40, 32'h0005_0001);
        obi_write(8'h04, 32'd1);
        obi_write(8'h00, 32'h1);
        wait_start("rstmid_start");
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({start, stop, busy, done, rsp.rvalid} !== 11'b0) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: start=%h stop=%h busy=%b done=%b rvalid=%b, required all 0",
                     start, stop, busy, done, rsp.rvalid);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (start !== 4'h0 || stop !== 4'h0) n_strobe++;
            tick();
        end
        tests_run++;
        if (n_strobe != 0) begin
            tests_failed++;
            $display("FAIL rstmid_no_strobe: strobe cycles=%0d, required 0", n_strobe);
        end
        obi_read(8'h04, 32'h0, "rstmid_len_cleared");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        req   = '0;
        ready = 4'hF;
        test_reset();
        test_map();
        test_basic();
        test_wait_rdy();
        test_abort();
        test_len_zero();
        test_back_to_back();
        test_loop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
